// File: rtl/ex_muldiv.sv
// Multi-cycle RV32M multiply/divide unit: shift-add multiply, restoring divide, start/done handshake.
// Optional MULDIV_FAST_MUL_EN: MUL* ops use a single-cycle combinational multiplier.
module ex_muldiv #(
    parameter int XLEN       = 32,
    parameter int REG_ADDR_W = 5
) (
    input  logic                  clk,
    input  logic                  rst_n,
    input  logic                  start_i,
    input  logic                  flush_i,
    input  logic [2:0]            op_i,
    input  logic [XLEN-1:0]       a_i,
    input  logic [XLEN-1:0]       b_i,
    input  logic [REG_ADDR_W-1:0] w_addr_i,
    output logic                  busy_o,
    output logic                  stall_req_o,
    output logic                  done_o,
    output logic                  w_enable_o,
    output logic [REG_ADDR_W-1:0] w_addr_o,
    output logic [XLEN-1:0]       result_o
);
    localparam int CW = $clog2(XLEN);

    typedef enum logic [1:0] {IDLE, CALC, DONE} state_t;

    state_t                  state_q, state_d;
    logic [2:0]              op_q;
    logic [REG_ADDR_W-1:0]   addr_q;
    logic [XLEN-1:0]         mag_b_q;
    logic [XLEN-1:0]         result_q;
    logic [2*XLEN-1:0]       acc_q;
    logic [2*XLEN-1:0]       acc_step;
    logic [CW-1:0]           cnt_q;
    logic                    neg_q;
    logic                    neg_rem_q;

    logic                    accept;
    logic                    a_sgn, b_sgn, a_neg, b_neg;
    logic [XLEN-1:0]         mag_a_in, mag_b_in;
    logic                    div_zero, ovf, take_short;
    logic [XLEN-1:0]         special_res, short_res;
    logic [XLEN:0]           mul_sum, rem_sh, diff;

    // Sign fixup and result select, shared by the iterative and single-cycle paths.
    // acc layout: multiply = {high, low} product; divide = {remainder, quotient}.
    function automatic logic [XLEN-1:0] fixup(input logic [2:0] op, input logic [2*XLEN-1:0] full,
                                              input logic neg, input logic neg_rem);
        logic [2*XLEN-1:0] p;
        logic [XLEN-1:0]   q, r;
        p = neg ? -full : full;
        q = neg ? -full[XLEN-1:0] : full[XLEN-1:0];
        r = neg_rem ? -full[2*XLEN-1:XLEN] : full[2*XLEN-1:XLEN];
        if (!op[2])
            fixup = (op[1:0] == 2'b00) ? p[XLEN-1:0] : p[2*XLEN-1:XLEN];
        else if (!op[1])
            fixup = q;
        else
            fixup = r;
    endfunction

    // start_i is a level request sampled only in IDLE; done_o pulses for one cycle in DONE,
    // and a request still held during DONE is ignored rather than retriggering.
    assign accept = (state_q == IDLE) && start_i && !flush_i;

    assign a_sgn    = (op_i == 3'b001) || (op_i == 3'b010) || (op_i == 3'b100) || (op_i == 3'b110);
    assign b_sgn    = (op_i == 3'b001) || (op_i == 3'b100) || (op_i == 3'b110);
    assign a_neg    = a_sgn && a_i[XLEN-1];
    assign b_neg    = b_sgn && b_i[XLEN-1];
    assign mag_a_in = a_neg ? -a_i : a_i;
    assign mag_b_in = b_neg ? -b_i : b_i;

    assign div_zero    = op_i[2] && (b_i == '0);
    assign ovf         = op_i[2] && !op_i[0] && (a_i == {1'b1, {(XLEN-1){1'b0}}}) && (&b_i);
    assign special_res = div_zero ? (op_i[1] ? a_i : '1) : (op_i[1] ? '0 : a_i);

`ifdef MULDIV_FAST_MUL_EN
    logic [2*XLEN-1:0] fast_prod;
    assign fast_prod  = {{XLEN{1'b0}}, mag_a_in} * {{XLEN{1'b0}}, mag_b_in};
    assign take_short = div_zero || ovf || !op_i[2];
    assign short_res  = op_i[2] ? special_res : fixup(op_i, fast_prod, a_neg ^ b_neg, a_neg);
`else
    assign take_short = div_zero || ovf;
    assign short_res  = special_res;
`endif

    // One iteration: multiply adds mag_b into the high half then shifts right;
    // divide shifts the next dividend bit into the remainder and subtracts if it fits.
    always_comb begin
        mul_sum  = {1'b0, acc_q[2*XLEN-1:XLEN]} + {1'b0, (acc_q[0] ? mag_b_q : {XLEN{1'b0}})};
        rem_sh   = {acc_q[2*XLEN-1:XLEN], acc_q[XLEN-1]};
        diff     = rem_sh - {1'b0, mag_b_q};
        acc_step = acc_q;
        if (!op_q[2])
            acc_step = {mul_sum, acc_q[XLEN-1:1]};
        else if (!diff[XLEN])
            acc_step = {diff[XLEN-1:0], acc_q[XLEN-2:0], 1'b1};
        else
            acc_step = {rem_sh[XLEN-1:0], acc_q[XLEN-2:0], 1'b0};
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n)
            state_q <= IDLE;
        else
            state_q <= state_d;
    end

    always_comb begin
        state_d = state_q;
        case (state_q)
            IDLE:    if (accept) state_d = take_short ? DONE : CALC;
            CALC:    if (cnt_q == '0) state_d = DONE;
            DONE:    state_d = IDLE;
            default: state_d = IDLE;
        endcase
        if (flush_i)
            state_d = IDLE;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            op_q      <= '0;
            addr_q    <= '0;
            mag_b_q   <= '0;
            result_q  <= '0;
            acc_q     <= '0;
            cnt_q     <= '0;
            neg_q     <= 1'b0;
            neg_rem_q <= 1'b0;
        end else if (accept) begin
            op_q      <= op_i;
            addr_q    <= w_addr_i;
            mag_b_q   <= mag_b_in;
            acc_q     <= {{XLEN{1'b0}}, mag_a_in};
            cnt_q     <= CW'(XLEN - 1);
            neg_q     <= a_neg ^ b_neg;
            neg_rem_q <= a_neg;
            if (take_short)
                result_q <= short_res;
        end else if (state_q == CALC && !flush_i) begin
            acc_q <= acc_step;
            cnt_q <= cnt_q - CW'(1);
            if (cnt_q == '0)
                result_q <= fixup(op_q, acc_step, neg_q, neg_rem_q);
        end
    end

    assign busy_o      = (state_q != IDLE);
    assign done_o      = (state_q == DONE);
    assign w_enable_o  = done_o;
    assign stall_req_o = ((state_q == IDLE) && start_i) || (state_q == CALC);
    assign w_addr_o    = addr_q;
    assign result_o    = result_q;
endmodule

// File: tb/tb_ex_muldiv.sv
// Directed bench for ex_muldiv: driver pushes expected results, a done-driven monitor checks them.
module tb_ex_muldiv;
    localparam int XLEN = 32;
    localparam int AW   = 5;
`ifdef MULDIV_FAST_MUL_EN
    localparam int MUL_LAT = 1;
`else
    localparam int MUL_LAT = 33;
`endif
    localparam int DIV_LAT = 33;

    logic            clk = 1'b0;
    logic            rst_n = 1'b0;
    logic            start_i = 1'b0;
    logic            flush_i = 1'b0;
    logic [2:0]      op_i = '0;
    logic [XLEN-1:0] a_i = '0;
    logic [XLEN-1:0] b_i = '0;
    logic [AW-1:0]   w_addr_i = '0;
    logic            busy_o, stall_req_o, done_o, w_enable_o;
    logic [AW-1:0]   w_addr_o;
    logic [XLEN-1:0] result_o;

    ex_muldiv #(.XLEN(XLEN), .REG_ADDR_W(AW)) dut (
        .clk(clk), .rst_n(rst_n), .start_i(start_i), .flush_i(flush_i), .op_i(op_i),
        .a_i(a_i), .b_i(b_i), .w_addr_i(w_addr_i), .busy_o(busy_o), .stall_req_o(stall_req_o),
        .done_o(done_o), .w_enable_o(w_enable_o), .w_addr_o(w_addr_o), .result_o(result_o)
    );

    always #5 clk = ~clk;

    int cyc = 0;
    always @(posedge clk) cyc <= cyc + 1;

    int n_vec = 0;
    int n_err = 0;
    logic [XLEN-1:0] exp_q[$];
    logic [AW-1:0]   addr_q[$];
    int              t0_q[$];
    int              lat_q[$];

    task automatic check(input string name, input logic [63:0] act, input logic [63:0] exp);
        n_vec++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h (cycle %0d)", name, act, exp, cyc);
        end
    endtask

    always @(negedge clk) begin
        if (rst_n && done_o) begin
            if (exp_q.size() == 0) begin
                check("unexpected_done", 64'(done_o), 64'd0);
            end else begin
                logic [XLEN-1:0] e;
                logic [AW-1:0]   ea;
                int              t0, lat;
                e   = exp_q.pop_front();
                ea  = addr_q.pop_front();
                t0  = t0_q.pop_front();
                lat = lat_q.pop_front();
                check("result", 64'(result_o), 64'(e));
                check("w_addr", 64'(w_addr_o), 64'(ea));
                check("w_enable", 64'(w_enable_o), 64'd1);
                check("latency", 64'(cyc - t0), 64'(lat));
            end
        end
    end

    // Called at posedge+1; returns at posedge+1 of the first cycle after done_o.
    task automatic issue(input logic [2:0] op, input logic [XLEN-1:0] a, input logic [XLEN-1:0] b,
                         input logic [AW-1:0] addr, input logic [XLEN-1:0] exp_res,
                         input int lat, input bit chk_stall);
        exp_q.push_back(exp_res);
        addr_q.push_back(addr);
        t0_q.push_back(cyc);
        lat_q.push_back(lat);
        start_i  = 1'b1;
        op_i     = op;
        a_i      = a;
        b_i      = b;
        w_addr_i = addr;
        @(negedge clk);
        if (chk_stall) check("stall_c0", 64'(stall_req_o), 64'd1);
        @(posedge clk); #1;
        start_i = 1'b0;
        for (int k = 1; k <= lat; k++) begin
            @(negedge clk);
            if (chk_stall) check("stall", 64'(stall_req_o), (k < lat) ? 64'd1 : 64'd0);
            @(posedge clk); #1;
        end
    endtask

    task automatic check_idle_outputs(input string tag);
        check({tag, "_busy"}, 64'(busy_o), 64'd0);
        check({tag, "_stall"}, 64'(stall_req_o), 64'd0);
        check({tag, "_done"}, 64'(done_o), 64'd0);
        check({tag, "_wen"}, 64'(w_enable_o), 64'd0);
        check({tag, "_waddr"}, 64'(w_addr_o), 64'd0);
        check({tag, "_result"}, 64'(result_o), 64'd0);
    endtask

    initial begin
        #12;
        check_idle_outputs("reset");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;

        issue(3'b000, 32'h0000_0007, 32'hFFFF_FFFD, 5'd1, 32'hFFFF_FFEB, MUL_LAT, 1'b1);
        issue(3'b011, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd2, 32'hFFFF_FFFE, MUL_LAT, 1'b0);
        issue(3'b001, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd3, 32'h0000_0000, MUL_LAT, 1'b0);
        issue(3'b010, 32'hFFFF_FFFF, 32'hFFFF_FFFF, 5'd4, 32'hFFFF_FFFF, MUL_LAT, 1'b0);
        issue(3'b000, 32'hFFFF_FFFD, 32'hFFFF_FFFB, 5'd5, 32'h0000_000F, MUL_LAT, 1'b0);
        issue(3'b001, 32'h8000_0000, 32'h8000_0000, 5'd6, 32'h4000_0000, MUL_LAT, 1'b0);
        issue(3'b000, 32'h0000_0006, 32'h0000_0007, 5'd7, 32'h0000_002A, MUL_LAT, 1'b1);

        issue(3'b100, 32'hFFFF_FFF9, 32'h0000_0002, 5'd8,  32'hFFFF_FFFD, DIV_LAT, 1'b0);
        issue(3'b110, 32'hFFFF_FFF9, 32'h0000_0002, 5'd9,  32'hFFFF_FFFF, DIV_LAT, 1'b0);
        issue(3'b101, 32'd100,       32'd7,         5'd10, 32'd14,        DIV_LAT, 1'b0);
        issue(3'b111, 32'd100,       32'd7,         5'd11, 32'd2,         DIV_LAT, 1'b0);
        issue(3'b100, 32'hFFFF_FFF9, 32'hFFFF_FFFE, 5'd12, 32'h0000_0003, DIV_LAT, 1'b0);
        issue(3'b101, 32'h8000_0000, 32'hFFFF_FFFF, 5'd13, 32'h0000_0000, DIV_LAT, 1'b0);
        issue(3'b111, 32'h8000_0000, 32'hFFFF_FFFF, 5'd14, 32'h8000_0000, DIV_LAT, 1'b0);
        issue(3'b101, 32'd9,         32'd3,         5'd15, 32'd3,         DIV_LAT, 1'b1);

        issue(3'b100, 32'd5,         32'd0,         5'd16, 32'hFFFF_FFFF, 1, 1'b1);
        issue(3'b111, 32'd5,         32'd0,         5'd17, 32'd5,         1, 1'b0);
        issue(3'b100, 32'h8000_0000, 32'hFFFF_FFFF, 5'd18, 32'h8000_0000, 1, 1'b0);
        issue(3'b110, 32'h8000_0000, 32'hFFFF_FFFF, 5'd19, 32'h0000_0000, 1, 1'b0);

        // DIV aborted at its cycle 10; the following cycle must be idle and accept a new op.
        start_i = 1'b1; op_i = 3'b100; a_i = 32'd1000; b_i = 32'd3; w_addr_i = 5'd20;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (9) @(posedge clk);
        #1 flush_i = 1'b1;
        @(posedge clk); #1;
        flush_i = 1'b0;
        check("flush_busy", 64'(busy_o), 64'd0);
        issue(3'b000, 32'd3, 32'd4, 5'd21, 32'd12, MUL_LAT, 1'b0);

        // Reset asserted between edges while a divide is iterating.
        start_i = 1'b1; op_i = 3'b101; a_i = 32'd77; b_i = 32'd5; w_addr_i = 5'd22;
        @(posedge clk); #1;
        start_i = 1'b0;
        repeat (5) @(posedge clk);
        #3 rst_n = 1'b0;
        #1;
        check_idle_outputs("async_rst");
        @(negedge clk);
        rst_n = 1'b1;
        @(posedge clk); #1;
        issue(3'b000, 32'd2, 32'd3, 5'd23, 32'd6, MUL_LAT, 1'b0);

        repeat (3) @(posedge clk);
        check("queue_drained", 64'(exp_q.size()), 64'd0);
        $display("== %0d vectors applied, %0d miscompares ==", n_vec, n_err);
        $finish;
    end

    initial begin
        #500000;
        $display("FAIL watchdog: simulation did not complete, cycle %0d", cyc);
        $fatal(1, "watchdog expired");
    end
endmodule
